fpmu_vlp_seq: RTL and testbench
===============================

# fpmu_vlp_seq

Power-sequencing stage for the fabric-level VLP (very-low-power) mode. The block consumes the chip VLP-enable and wake-up-enable register bits, which the MIC state machine sets in the FRFU. It then drives isolation, the power switch and the fabric reset in a fixed order. When a sequence completes, it clears the requesting register bit, which releases the MIC state machine from its wait states. It also reports busy back to the MIC so that cfg-done generation is held off during a sequence.

## Interface
Parameters:
- PAR_TOUT_W, default 10: width of the power-ack timeout counter. Timeout fires after 2^PAR_TOUT_W-1 cycles without ack.

Ports:
- fcb_sys_clk  in  1  system clock
- fcb_sys_rst_n  in  1  reset; asynchronous, active-low
- frfu_fpmu_pmu_chip_vlp_en  in  1  power-down request (level, register bit)
- frfu_fpmu_pmu_chip_wu_en  in  1  wake-up request (level, register bit)
- frfu_fpmu_iso_wait  in  4  isolation settle time; phase lasts value+1 cycles
- frfu_fpmu_pwr_wait  in  8  post-ack power settle time; phase lasts value+1 cycles
- fpmu_fb_pwr_ack  in  1  power-switch chain status (1 = powered); already synchronized
- fpmu_fb_pwr_en  out  1  power-switch enable
- fpmu_fb_iso_n  out  1  fabric isolation, active-low
- fpmu_fb_rst_n  out  1  fabric reset, active-low
- fpmu_fmic_pmu_busy  out  1  sequence in progress
- fpmu_frfu_clr_pmu_chip_vlp_en  out  1  one-cycle clear pulse
- fpmu_frfu_clr_pmu_chip_wu_en  out  1  one-cycle clear pulse
- fpmu_frfu_pw_sta  out  2  00 on, 01 powering down, 10 off, 11 powering up
- fpmu_frfu_ack_tout  out  1  one-cycle pulse on ack timeout

## Operation
- States: ON, ISO, PDN, OFF, PUP, SETTLE, DEISO.
- Reset values: state ON; pwr_en=1, iso_n=1, rst_n=1; busy=0; both clear pulses 0; pw_sta=00; ack_tout=0.
- **ON**
  - If vlp_en=1: go to ISO, set iso_n=0, load the counter with iso_wait.
  - Else if wu_en=1: pulse clr_wu_en (stale wake request) and stay in ON.
- **ISO**: decrement the counter. At 0: go to PDN, set pwr_en=0 and rst_n=0, clear the timeout counter.
- **PDN**: wait for pwr_ack=0, or for the timeout to fire (which also pulses ack_tout). Then go to OFF and pulse clr_vlp_en.
- **OFF**
  - If wu_en=1: go to PUP, set pwr_en=1, clear the timeout counter.
  - Else if vlp_en=1: pulse clr_vlp_en (redundant request) and stay in OFF.
- **PUP**: wait for pwr_ack=1, or for the timeout (which also pulses ack_tout). Then go to SETTLE and load the counter with pwr_wait.
- **SETTLE**: decrement. At 0: go to DEISO, set iso_n=1, load the counter with iso_wait.
- **DEISO**: decrement. At 0: go to ON, set rst_n=1, pulse clr_wu_en.
- vlp_en and wu_en both 1 in ON: the power-down request is taken; wu_en is untouched and is served in OFF. This gives a round trip.
- Requests that arrive mid-sequence are ignored until ON or OFF is reached. Register bits are levels, so nothing is lost.
- busy = state not in {ON, OFF}.
- pw_sta by state:
  - ON: 00
  - ISO/PDN: 01
  - OFF: 10
  - PUP/SETTLE/DEISO: 11
- Wait counters are unsigned and load the full input value, so 0 gives 1 cycle. The wait inputs are sampled only at load.
- Asynchronous reset mid-sequence returns the block to ON with power enabled and isolation released. The FRFU reset clears the request bits in the same domain.

## Timing
- All outputs are registered and change on the same edge as the state transition.
- Request sampled at edge k:
  - iso_n falls and busy rises at edge k.
  - pwr_en and rst_n fall at edge k+iso_wait+1.
- Ack-low sampled at edge m: state becomes OFF and clr_vlp_en is high for the cycle following edge m.
- Wake sampled at edge j: pwr_en rises at edge j.
- Ack-high sampled at edge p:
  - iso_n rises at edge p+pwr_wait+1.
  - rst_n rises, clr_wu_en pulses and busy falls at edge p+pwr_wait+iso_wait+2.
- Timeout: with no ack, the exit edge is entry+2^PAR_TOUT_W-1, and ack_tout pulses on that cycle.
- Minimum power-down latency is iso_wait+2 cycles. Minimum wake latency is pwr_wait+iso_wait+3 cycles.

## Structure
- fpmu_pkg holds:
  - the state enum (logic [2:0])
  - the pw_sta localparams PW_ON/PW_PDN/PW_OFF/PW_PUP
- Sub-module fpmu_wait_cnt: an 8-bit loadable down-counter with a zero flag. It is used for both iso_wait and pwr_wait; the timeout uses a separate up-counter.

## Test plan
- Reset, then vlp_en=1 with iso_wait=3 and ack dropping 5 cycles after pwr_en falls:
  - iso_n falls at k, pwr_en and rst_n fall at k+4.
  - clr_vlp_en pulses once, pw_sta goes 01 then 10, busy is high for exactly the sequence.
- In OFF, wu_en=1 with pwr_wait=10, iso_wait=2, and ack rising 7 cycles after pwr_en:
  - iso_n rises 11 cycles after ack.
  - rst_n rises and clr_wu_en pulses 3 cycles after that; pw_sta=00.
- vlp_en and wu_en both 1 in ON: full power-down, then immediate power-up. Exactly one clr_vlp_en, then one clr_wu_en.
- Ack held at 1 during PDN with PAR_TOUT_W=4: ack_tout pulses 15 cycles after PDN entry, and the block enters OFF.
- Stale requests: wu_en=1 in ON gives a clr_wu_en pulse and no state change. vlp_en=1 in OFF gives a clr_vlp_en pulse.
- Reset asserted in SETTLE: outputs return to pwr_en=1, iso_n=1, rst_n=1, busy=0, pw_sta=00.

Source files
------------

// File: rtl/fpmu_pkg.sv
// fpmu_pkg: shared types and constants for the fabric VLP power sequencer.
//   fpmu_state_e : sequencer state encoding
//   PW_*         : encodings of the power-status field reported to the FRFU
//   pw_sta_of()  : maps a sequencer state to its power-status code
package fpmu_pkg;

    typedef enum logic [2:0] {
        ST_ON     = 3'd0,
        ST_ISO    = 3'd1,
        ST_PDN    = 3'd2,
        ST_OFF    = 3'd3,
        ST_PUP    = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DEISO  = 3'd6
    } fpmu_state_e;

    localparam logic [1:0] PW_ON  = 2'b00;
    localparam logic [1:0] PW_PDN = 2'b01;
    localparam logic [1:0] PW_OFF = 2'b10;
    localparam logic [1:0] PW_PUP = 2'b11;

    function automatic logic [1:0] pw_sta_of(input fpmu_state_e s);
        logic [1:0] sta;
        case (s)
            ST_ON:                        sta = PW_ON;
            ST_ISO, ST_PDN:               sta = PW_PDN;
            ST_OFF:                       sta = PW_OFF;
            ST_PUP, ST_SETTLE, ST_DEISO:  sta = PW_PUP;
            default:                      sta = PW_ON;
        endcase
        return sta;
    endfunction

endpackage

// File: rtl/fpmu_wait_cnt.sv
// fpmu_wait_cnt: 8-bit loadable down-counter with zero flag, shared by the
// isolation-settle and power-settle phases.
//   fcb_sys_clk, fcb_sys_rst_n : clock, asynchronous active-low reset
//   i_load, i_load_val         : load the counter (has priority over i_dec)
//   i_dec                      : decrement by one, holding at zero
//   o_zero                     : counter currently reads zero
module fpmu_wait_cnt
    import fpmu_pkg::*;
(
    input  logic       fcb_sys_clk,
    input  logic       fcb_sys_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/fpmu_vlp_seq.sv
// fpmu_vlp_seq: fabric VLP power sequencer. Drives isolation, power switch and
// fabric reset in a fixed order on power-down / wake-up requests, clears the
// requesting register bit when done and reports busy to the MIC.
//   frfu_fpmu_pmu_chip_vlp_en / _wu_en : request levels from FRFU registers
//   frfu_fpmu_iso_wait / _pwr_wait     : settle times (phase = value+1 cycles)
//   fpmu_fb_pwr_ack                    : synchronized power-switch status
//   fpmu_fb_pwr_en/_iso_n/_rst_n       : fabric power controls (registered)
//   fpmu_fmic_pmu_busy                 : sequence in progress
//   fpmu_frfu_clr_*                    : one-cycle request clear pulses
//   fpmu_frfu_pw_sta                   : power status code
//   fpmu_frfu_ack_tout                 : one-cycle pulse on ack timeout
module fpmu_vlp_seq
    import fpmu_pkg::*;
#(
    parameter int PAR_TOUT_W = 10
) (
    input  logic       fcb_sys_clk,
    input  logic       fcb_sys_rst_n,
    input  logic       frfu_fpmu_pmu_chip_vlp_en,
    input  logic       frfu_fpmu_pmu_chip_wu_en,
    input  logic [3:0] frfu_fpmu_iso_wait,
    input  logic [7:0] frfu_fpmu_pwr_wait,
    input  logic       fpmu_fb_pwr_ack,
    output logic       fpmu_fb_pwr_en,
    output logic       fpmu_fb_iso_n,
    output logic       fpmu_fb_rst_n,
    output logic       fpmu_fmic_pmu_busy,
    output logic       fpmu_frfu_clr_pmu_chip_vlp_en,
    output logic       fpmu_frfu_clr_pmu_chip_wu_en,
    output logic [1:0] fpmu_frfu_pw_sta,
    output logic       fpmu_frfu_ack_tout
);

    // Counter value seen on the edge before the (2^W-1)th waiting edge.
    localparam logic [PAR_TOUT_W-1:0] TOUT_LAST = {{(PAR_TOUT_W-1){1'b1}}, 1'b0};

    fpmu_state_e           r_state, w_state_nxt;
    logic [PAR_TOUT_W-1:0] r_tout_cnt;
    logic                  r_pwr_en, r_iso_n, r_rst_n, r_busy;
    logic                  r_clr_vlp, r_clr_wu, r_ack_tout;
    logic [1:0]            r_pw_sta;

    logic       w_pwr_en_nxt, w_iso_n_nxt, w_rst_n_nxt;
    logic       w_clr_vlp_nxt, w_clr_wu_nxt, w_ack_tout_nxt;
    logic       w_tout_clr, w_tout_inc, w_tout_hit;
    logic       w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [7:0] w_cnt_val;

    fpmu_wait_cnt u_wait_cnt (
        .fcb_sys_clk   (fcb_sys_clk),
        .fcb_sys_rst_n (fcb_sys_rst_n),
        .i_load        (w_cnt_load),
        .i_load_val    (w_cnt_val),
        .i_dec         (w_cnt_dec),
        .o_zero        (w_cnt_zero)
    );

    assign w_tout_hit = (r_tout_cnt == TOUT_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_pwr_en_nxt   = r_pwr_en;
        w_iso_n_nxt    = r_iso_n;
        w_rst_n_nxt    = r_rst_n;
        w_clr_vlp_nxt  = 1'b0;
        w_clr_wu_nxt   = 1'b0;
        w_ack_tout_nxt = 1'b0;
        w_tout_clr     = 1'b0;
        w_tout_inc     = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        w_cnt_val      = {4'd0, frfu_fpmu_iso_wait};
        case (r_state)
            ST_ON: begin
                // Power-down wins; a simultaneous wake request stays set and
                // is served from OFF, giving a full round trip.
                if (frfu_fpmu_pmu_chip_vlp_en) begin
                    w_state_nxt = ST_ISO;
                    w_iso_n_nxt = 1'b0;
                    w_cnt_load  = 1'b1;
                end else if (frfu_fpmu_pmu_chip_wu_en) begin
                    w_clr_wu_nxt = 1'b1;
                end
            end
            ST_ISO: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt  = ST_PDN;
                    w_pwr_en_nxt = 1'b0;
                    w_rst_n_nxt  = 1'b0;
                    w_tout_clr   = 1'b1;
                end
            end
            ST_PDN: begin
                w_tout_inc = 1'b1;
                if (!fpmu_fb_pwr_ack || w_tout_hit) begin
                    w_state_nxt    = ST_OFF;
                    w_clr_vlp_nxt  = 1'b1;
                    w_ack_tout_nxt = fpmu_fb_pwr_ack;
                end
            end
            ST_OFF: begin
                if (frfu_fpmu_pmu_chip_wu_en) begin
                    w_state_nxt  = ST_PUP;
                    w_pwr_en_nxt = 1'b1;
                    w_tout_clr   = 1'b1;
                end else if (frfu_fpmu_pmu_chip_vlp_en) begin
                    w_clr_vlp_nxt = 1'b1;
                end
            end
            ST_PUP: begin
                w_tout_inc = 1'b1;
                w_cnt_val  = frfu_fpmu_pwr_wait;
                if (fpmu_fb_pwr_ack || w_tout_hit) begin
                    w_state_nxt    = ST_SETTLE;
                    w_cnt_load     = 1'b1;
                    w_ack_tout_nxt = !fpmu_fb_pwr_ack;
                end
            end
            ST_SETTLE: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DEISO;
                    w_iso_n_nxt = 1'b1;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_DEISO: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt  = ST_ON;
                    w_rst_n_nxt  = 1'b1;
                    w_clr_wu_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ON;
            end
        endcase
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            r_state    <= ST_ON;
            r_tout_cnt <= '0;
            r_pwr_en   <= 1'b1;
            r_iso_n    <= 1'b1;
            r_rst_n    <= 1'b1;
            r_busy     <= 1'b0;
            r_clr_vlp  <= 1'b0;
            r_clr_wu   <= 1'b0;
            r_ack_tout <= 1'b0;
            r_pw_sta   <= PW_ON;
        end else begin
            r_state    <= w_state_nxt;
            if (w_tout_clr) begin
                r_tout_cnt <= '0;
            end else if (w_tout_inc) begin
                r_tout_cnt <= r_tout_cnt + 1'b1;
            end
            r_pwr_en   <= w_pwr_en_nxt;
            r_iso_n    <= w_iso_n_nxt;
            r_rst_n    <= w_rst_n_nxt;
            // Status outputs are decoded from the next state so they switch
            // on the same edge as the transition itself.
            r_busy     <= (w_state_nxt != ST_ON) && (w_state_nxt != ST_OFF);
            r_clr_vlp  <= w_clr_vlp_nxt;
            r_clr_wu   <= w_clr_wu_nxt;
            r_ack_tout <= w_ack_tout_nxt;
            r_pw_sta   <= pw_sta_of(w_state_nxt);
        end
    end

    assign fpmu_fb_pwr_en                = r_pwr_en;
    assign fpmu_fb_iso_n                 = r_iso_n;
    assign fpmu_fb_rst_n                 = r_rst_n;
    assign fpmu_fmic_pmu_busy            = r_busy;
    assign fpmu_frfu_clr_pmu_chip_vlp_en = r_clr_vlp;
    assign fpmu_frfu_clr_pmu_chip_wu_en  = r_clr_wu;
    assign fpmu_frfu_pw_sta              = r_pw_sta;
    assign fpmu_frfu_ack_tout            = r_ack_tout;

endmodule

// File: tb/tb_fpmu_vlp_seq.sv
// tb_fpmu_vlp_seq: directed, table-driven bench for fpmu_vlp_seq.
// Outputs are packed as {pwr_en, iso_n, rst_n, busy, clr_vlp, clr_wu,
// pw_sta[1:0], ack_tout} and compared 1 ns after each rising edge.
module tb_fpmu_vlp_seq;

    localparam logic [8:0] E_ON     = 9'b1_1_1_0_0_0_00_0;
    localparam logic [8:0] E_ON_CW  = 9'b1_1_1_0_0_1_00_0;
    localparam logic [8:0] E_ISO    = 9'b1_0_1_1_0_0_01_0;
    localparam logic [8:0] E_PDN    = 9'b0_0_0_1_0_0_01_0;
    localparam logic [8:0] E_OFF    = 9'b0_0_0_0_0_0_10_0;
    localparam logic [8:0] E_OFF_CV = 9'b0_0_0_0_1_0_10_0;
    localparam logic [8:0] E_OFF_TO = 9'b0_0_0_0_1_0_10_1;
    localparam logic [8:0] E_PUP    = 9'b1_0_0_1_0_0_11_0;
    localparam logic [8:0] E_DEISO  = 9'b1_1_0_1_0_0_11_0;

    typedef struct {
        logic       vlp;
        logic       wu;
        logic       ack;
        logic [3:0] iso;
        logic [7:0] pwr;
        logic [8:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vlp, wu, ack;
    logic [3:0] iso;
    logic [7:0] pwr;
    logic       pwr_en, iso_n, fb_rst_n, busy, clr_vlp, clr_wu, ack_tout;
    logic [1:0] pw_sta;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[34];

    fpmu_vlp_seq #(.PAR_TOUT_W(4)) dut (
        .fcb_sys_clk                   (clk),
        .fcb_sys_rst_n                 (rst_n),
        .frfu_fpmu_pmu_chip_vlp_en     (vlp),
        .frfu_fpmu_pmu_chip_wu_en      (wu),
        .frfu_fpmu_iso_wait            (iso),
        .frfu_fpmu_pwr_wait            (pwr),
        .fpmu_fb_pwr_ack               (ack),
        .fpmu_fb_pwr_en                (pwr_en),
        .fpmu_fb_iso_n                 (iso_n),
        .fpmu_fb_rst_n                 (fb_rst_n),
        .fpmu_fmic_pmu_busy            (busy),
        .fpmu_frfu_clr_pmu_chip_vlp_en (clr_vlp),
        .fpmu_frfu_clr_pmu_chip_wu_en  (clr_wu),
        .fpmu_frfu_pw_sta              (pw_sta),
        .fpmu_frfu_ack_tout            (ack_tout)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {pwr_en, iso_n, fb_rst_n, busy, clr_vlp, clr_wu, pw_sta, ack_tout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cv, n_cw, done_at, order_ok, saw_off, tout_at;
        logic [8:0] tout_outs;

        // Power-down: iso_wait=3, ack drops 5 edges after pwr_en falls.
        for (int i = 0; i < 4; i++)   tbl[i] = '{1'b1, 1'b0, 1'b1, 4'd3, 8'd10, E_ISO};
        for (int i = 4; i < 9; i++)   tbl[i] = '{1'b1, 1'b0, 1'b1, 4'd3, 8'd10, E_PDN};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd3, 8'd10, E_OFF_CV};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd3, 8'd10, E_OFF};
        // Wake: pwr_wait=10, iso_wait=2, ack rises 7 edges after pwr_en.
        for (int i = 11; i < 18; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 4'd2, 8'd10, E_PUP};
        for (int i = 18; i < 29; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'd10, E_PUP};
        for (int i = 29; i < 32; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'd10, E_DEISO};
        tbl[32] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'd10, E_ON_CW};
        tbl[33] = '{1'b0, 1'b0, 1'b1, 4'd2, 8'd10, E_ON};

        rst_n = 1'b0; vlp = 1'b0; wu = 1'b0; ack = 1'b1; iso = 4'd0; pwr = 8'd0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_hold", outs(), E_ON);
        rst_n = 1'b1;
        tick();
        check("reset_idle", outs(), E_ON);

        for (int i = 0; i < 34; i++) begin
            vlp = tbl[i].vlp; wu = tbl[i].wu; ack = tbl[i].ack;
            iso = tbl[i].iso; pwr = tbl[i].pwr;
            tick();
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Both requests in ON: round trip, ack follows pwr_en one cycle late.
        vlp = 1'b1; wu = 1'b1; iso = 4'd0; pwr = 8'd0; ack = 1'b1;
        n_cv = 0; n_cw = 0; done_at = 0; order_ok = 1; saw_off = 0;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            tick();
            if (clr_vlp) begin n_cv++; vlp = 1'b0; end
            if (clr_wu) begin
                n_cw++;
                if (n_cv == 0) order_ok = 0;
                wu = 1'b0;
                done_at = c;
            end
            if (pw_sta == 2'b10) saw_off = 1;
            ack = pwr_en;
        end
        check_int("both_clr_vlp_cnt", n_cv, 1);
        check_int("both_clr_wu_cnt", n_cw, 1);
        check_int("both_order", order_ok, 1);
        check_int("both_saw_off", saw_off, 1);
        check_int("both_latency", done_at, 7);
        tick();
        check("both_end_on", outs(), E_ON);

        // Ack stuck high in PDN: timeout 15 edges after PDN entry.
        vlp = 1'b1; ack = 1'b1; iso = 4'd0;
        tick();
        check("tout_iso", outs(), E_ISO);
        tick();
        check("tout_pdn_entry", outs(), E_PDN);
        tout_at = 0; tout_outs = '0;
        for (int c = 1; c <= 40 && tout_at == 0; c++) begin
            tick();
            if (ack_tout) begin tout_at = c; tout_outs = outs(); end
        end
        check_int("tout_latency", tout_at, 15);
        check("tout_exit", tout_outs, E_OFF_TO);
        vlp = 1'b0;
        tick();
        check("tout_pulse_end", outs(), E_OFF);

        // Stale power-down request in OFF.
        vlp = 1'b1;
        tick();
        check("stale_vlp_off", outs(), E_OFF_CV);
        vlp = 1'b0;
        tick();
        check("stale_vlp_clr", outs(), E_OFF);

        // Short wake back to ON (ack already high).
        wu = 1'b1; pwr = 8'd0; iso = 4'd0;
        repeat (3) tick();
        check("wake_deiso", outs(), E_DEISO);
        tick();
        check("wake_on", outs(), E_ON_CW);
        wu = 1'b0;
        tick();
        check("wake_idle", outs(), E_ON);

        // Stale wake request in ON.
        wu = 1'b1;
        tick();
        check("stale_wu_on", outs(), E_ON_CW);
        wu = 1'b0;
        tick();
        check("stale_wu_clr", outs(), E_ON);

        // Asynchronous reset while in SETTLE.
        pwr = 8'd200; iso = 4'd0; vlp = 1'b1; ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        tick();
        check("rst_seq_off", outs(), E_OFF_CV);
        vlp = 1'b0; wu = 1'b1;
        tick();
        ack = 1'b1;
        repeat (3) tick();
        check("rst_seq_settle", outs(), E_PUP);
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), E_ON);
        wu = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_release", outs(), E_ON);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
